// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants, state type and helpers for the FIX message builder
//
// Purpose: common definitions imported by the BodyLength generator and the
//          sequential binary-to-BCD converter.
// Contents:
//   ASCII_ZERO   ASCII code of digit '0'
//   DELIM_BYTES  bytes added per field for '=' and SOH
//   state_t      generator FSM states
//   max_val()    largest value representable in a given number of decimal digits

package fix_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam int         DELIM_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CONVERT,
    EMIT
  } state_t;

  // 10^digits - 1, evaluated at elaboration time for saturation limits.
  function automatic int max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
//
// Purpose: converts BIN_WIDTH-bit binary to DIGITS BCD nibbles, one bit per
//          cycle, MSB first. The input must be below 10^DIGITS.
// Ports:
//   clk    in   clock
//   rst    in   synchronous, active-low reset
//   start  in   load bin and begin a conversion (ignored while busy)
//   bin    in   BIN_WIDTH  binary value sampled on start
//   busy   out  conversion in progress
//   last   out  the current cycle performs the final shift
//   done   out  one-cycle pulse; bcd holds the result
//   bcd    out  4*DIGITS  packed BCD, nibble 0 least significant; held until next start

module bin2bcd_seq #(
  parameter int BIN_WIDTH = 17,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  last,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  logic [BIN_WIDTH-1:0] bin_sh;
  logic [CNT_W-1:0]     cnt;
  logic [4*DIGITS-1:0]  adj;

  // Add-3 correction so every nibble carries correctly into the next after the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  assign last = busy && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_sh <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      bcd    <= '0;
    end else begin
      done <= last;
      if (start && !busy) begin
        bin_sh <= bin;
        bcd    <= '0;
        cnt    <= CNT_W'(BIN_WIDTH);
        busy   <= 1'b1;
      end else if (busy) begin
        bcd    <= {adj[4*DIGITS-2:0], bin_sh[BIN_WIDTH-1]};
        bin_sh <= {bin_sh[BIN_WIDTH-2:0], 1'b0};
        cnt    <= cnt - 1'b1;
        if (last) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fix_bodylength_gen.sv
// rtl/fix_bodylength_gen.sv - streaming FIX BodyLength accumulator and ASCII generator
//
// Purpose: sums per-field byte counts (plus delimiters and a constant header
//          length), saturates at 10^MAX_DIGITS-1, converts to decimal and presents
//          the result as a left-justified ASCII word and a digit byte stream.
// Ports:
//   clk           in   clock
//   rst           in   synchronous, active-low reset
//   start_i       in   begin new message (IDLE only)
//   fld_valid_i   in   field length valid
//   fld_ready_o   out  field lengths accepted (ACCUM)
//   fld_len_i     in   FLD_WIDTH  tag+value byte count
//   fld_last_i    in   final field of the message
//   busy_o        out  not idle
//   done_o        out  one-cycle pulse, result valid
//   ascii_o       out  8*MAX_DIGITS  byte k = k-th most significant digit, unused bytes 0
//   size_o        out  number of significant digits
//   overflow_o    out  sticky saturation flag, cleared on accepted start
//   byte_o        out  8  serial ASCII digit
//   byte_valid_o  out  serial digit valid
//   byte_ready_i  in   downstream accepts digit
//   byte_last_o   out  final digit

module fix_bodylength_gen
  import fix_pkg::*;
#(
  parameter int LEN_WIDTH  = 17,
  parameter int MAX_DIGITS = 5,
  parameter int FLD_WIDTH  = 8,
  parameter int BASE_LEN   = 0,
  parameter int ADD_DELIM  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic                              fld_valid_i,
  output logic                              fld_ready_o,
  input  logic [FLD_WIDTH-1:0]              fld_len_i,
  input  logic                              fld_last_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [8*MAX_DIGITS-1:0]           ascii_o,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   size_o,
  output logic                              overflow_o,
  output logic [7:0]                        byte_o,
  output logic                              byte_valid_o,
  input  logic                              byte_ready_i,
  output logic                              byte_last_o
);

  localparam int SIZE_W = $clog2(MAX_DIGITS + 1);
  localparam logic [LEN_WIDTH-1:0] MAX_VAL   = LEN_WIDTH'(max_val(MAX_DIGITS));
  localparam logic [LEN_WIDTH-1:0] FLD_EXTRA = (ADD_DELIM != 0) ? LEN_WIDTH'(DELIM_BYTES) : '0;

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    acc;
  logic [LEN_WIDTH-1:0]    sum;
  logic                    overflow_q;
  logic                    res_valid;
  logic [SIZE_W-1:0]       idx;
  logic                    fld_hs;
  logic                    start_hs;
  logic                    conv_start;
  logic                    conv_busy;
  logic                    conv_last;
  logic                    conv_done;
  logic [4*MAX_DIGITS-1:0] conv_bcd;
  logic [8*MAX_DIGITS-1:0] ascii_c;
  logic [SIZE_W-1:0]       size_c;
  logic [7:0]              byte_sel;
  logic                    last_digit;
  int                      hi;

  bin2bcd_seq #(
    .BIN_WIDTH (LEN_WIDTH),
    .DIGITS    (MAX_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (acc),
    .busy  (conv_busy),
    .last  (conv_last),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // The constraint on LEN_WIDTH guarantees this sum never wraps, since acc <= MAX_VAL.
  assign sum      = acc + LEN_WIDTH'(fld_len_i) + FLD_EXTRA;
  assign fld_hs   = fld_valid_i && (state == ACCUM);
  assign start_hs = start_i && (state == IDLE);

  // Leading-zero suppression: hi is the most significant nonzero digit; zero keeps one digit.
  always_comb begin
    hi = 0;
    for (int j = 0; j < MAX_DIGITS; j++) begin
      if (conv_bcd[4*j +: 4] != 4'd0) hi = j;
    end
    size_c  = SIZE_W'(hi + 1);
    ascii_c = '0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      for (int j = 0; j < MAX_DIGITS; j++) begin
        if (j == hi - k) ascii_c[8*k +: 8] = ASCII_ZERO + {4'h0, conv_bcd[4*j +: 4]};
      end
    end
  end

  // The converter keeps its BCD after done; res_valid masks it to zero after reset/start.
  assign ascii_o    = res_valid ? ascii_c : '0;
  assign size_o     = res_valid ? size_c  : '0;
  assign overflow_o = overflow_q;
  assign last_digit = (idx == size_c - 1'b1);

  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (idx == SIZE_W'(k)) byte_sel = ascii_c[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fld_ready_o  = 1'b0;
    busy_o       = (state != IDLE);
    done_o       = 1'b0;
    byte_valid_o = 1'b0;
    byte_last_o  = 1'b0;
    byte_o       = '0;
    conv_start   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = ACCUM;
      end
      ACCUM: begin
        fld_ready_o = 1'b1;
        if (fld_valid_i && fld_last_i) state_nxt = CONVERT;
      end
      CONVERT: begin
        // First CONVERT cycle loads the converter; the final shift moves us to EMIT.
        conv_start = !conv_busy;
        if (conv_last) state_nxt = EMIT;
      end
      EMIT: begin
        done_o       = conv_done;
        byte_valid_o = 1'b1;
        byte_last_o  = last_digit;
        byte_o       = byte_sel;
        if (byte_ready_i && last_digit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      overflow_q <= 1'b0;
      res_valid  <= 1'b0;
      idx        <= '0;
    end else begin
      if (start_hs) begin
        acc        <= LEN_WIDTH'(BASE_LEN);
        overflow_q <= 1'b0;
        res_valid  <= 1'b0;
      end else if (fld_hs) begin
        if (sum > MAX_VAL) begin
          acc        <= MAX_VAL;
          overflow_q <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
      if (conv_last) begin
        res_valid <= 1'b1;
        idx       <= '0;
      end else if (state == EMIT && byte_ready_i && !last_digit) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fix_bodylength_gen.sv
// tb/tb_fix_bodylength_gen.sv - self-checking bench for fix_bodylength_gen
//
// Three instances share one stimulus: u0 defaults, u1 without delimiters,
// u2 with a 49-byte header. Each result is compared with a decimal-string model.

module tb_fix_bodylength_gen;

  localparam int NI   = 3;
  localparam int LW   = 17;
  localparam int MAXV = 99999;
  localparam int BASE  [NI] = '{0, 0, 49};
  localparam int DELIM [NI] = '{2, 0, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       fld_valid = 1'b0;
  logic       fld_last = 1'b0;
  logic [7:0] fld_len = 8'd0;
  logic       byte_ready = 1'b0;

  logic        frdy  [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        ovf   [NI];
  logic        bv    [NI];
  logic        bl    [NI];
  logic [7:0]  bo    [NI];
  logic [39:0] ascii [NI];
  logic [2:0]  size  [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_edge = 0;
  int done_cnt [NI];
  int done_cyc [NI];
  logic [39:0] cap_ascii [NI];
  logic [2:0]  cap_size  [NI];
  logic [7:0]  got [NI][8];
  int got_n   [NI];
  int last_at [NI];
  int lens [$];

  always #5 clk = ~clk;

  fix_bodylength_gen u0 (
    .clk(clk), .rst(rst), .start_i(start), .fld_valid_i(fld_valid), .fld_ready_o(frdy[0]),
    .fld_len_i(fld_len), .fld_last_i(fld_last), .busy_o(busy[0]), .done_o(done[0]),
    .ascii_o(ascii[0]), .size_o(size[0]), .overflow_o(ovf[0]), .byte_o(bo[0]),
    .byte_valid_o(bv[0]), .byte_ready_i(byte_ready), .byte_last_o(bl[0]));

  fix_bodylength_gen #(.ADD_DELIM(0)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .fld_valid_i(fld_valid), .fld_ready_o(frdy[1]),
    .fld_len_i(fld_len), .fld_last_i(fld_last), .busy_o(busy[1]), .done_o(done[1]),
    .ascii_o(ascii[1]), .size_o(size[1]), .overflow_o(ovf[1]), .byte_o(bo[1]),
    .byte_valid_o(bv[1]), .byte_ready_i(byte_ready), .byte_last_o(bl[1]));

  fix_bodylength_gen #(.BASE_LEN(49)) u2 (
    .clk(clk), .rst(rst), .start_i(start), .fld_valid_i(fld_valid), .fld_ready_o(frdy[2]),
    .fld_len_i(fld_len), .fld_last_i(fld_last), .busy_o(busy[2]), .done_o(done[2]),
    .ascii_o(ascii[2]), .size_o(size[2]), .overflow_o(ovf[2]), .byte_o(bo[2]),
    .byte_valid_o(bv[2]), .byte_ready_i(byte_ready), .byte_last_o(bl[2]));

  always @(posedge clk) cyc++;

  // Observe on the falling edge; inputs change 1 time unit after the rising edge.
  always @(negedge clk) begin
    if (fld_valid && frdy[0] && fld_last) hs_edge = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i]  = cyc;
        cap_ascii[i] = ascii[i];
        cap_size[i]  = size[i];
      end
      if (bv[i] && byte_ready) begin
        if (got_n[i] < 8) got[i][got_n[i]] = bo[i];
        if (bl[i]) last_at[i] = got_n[i];
        got_n[i]++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < NI; i++) begin
      done_cnt[i] = 0;
      got_n[i]    = 0;
      last_at[i]  = -1;
    end
  endtask

  task automatic send_fields(input bit gaps);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (lens[f]) begin
      chk($sformatf("fld_ready_f%0d", f), frdy[0], 1);
      fld_valid = 1'b1;
      fld_len   = 8'(lens[f]);
      fld_last  = (f == lens.size() - 1);
      tick();
      fld_valid = 1'b0;
      fld_last  = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 400) begin
      byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("idle_timeout", n < 400, 1);
    byte_ready = 1'b0;
    tick();
  endtask

  task automatic check_msg(input string name);
    longint      tot;
    int          expv;
    string       s;
    logic [39:0] ea;
    for (int i = 0; i < NI; i++) begin
      tot = BASE[i];
      foreach (lens[f]) tot += lens[f] + DELIM[i];
      expv = (tot > MAXV) ? MAXV : int'(tot);
      s  = $sformatf("%0d", expv);
      ea = '0;
      for (int k = 0; k < s.len(); k++) ea[8*k +: 8] = s[k];
      chk($sformatf("%s/u%0d/done_count", name, i), done_cnt[i], 1);
      chk($sformatf("%s/u%0d/latency", name, i), done_cyc[i] - hs_edge, LW + 1);
      chk($sformatf("%s/u%0d/overflow", name, i), ovf[i], tot > MAXV);
      chk($sformatf("%s/u%0d/size", name, i), cap_size[i], s.len());
      chk($sformatf("%s/u%0d/ascii", name, i), cap_ascii[i], ea);
      chk($sformatf("%s/u%0d/ascii_held", name, i), ascii[i], ea);
      chk($sformatf("%s/u%0d/byte_count", name, i), got_n[i], s.len());
      chk($sformatf("%s/u%0d/last_pos", name, i), last_at[i], s.len() - 1);
      for (int k = 0; k < s.len() && k < 8; k++)
        chk($sformatf("%s/u%0d/byte%0d", name, i, k), got[i][k], s[k]);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s/u%0d/busy", name, i), busy[i], 0);
      chk($sformatf("%s/u%0d/fld_ready", name, i), frdy[i], 0);
      chk($sformatf("%s/u%0d/done", name, i), done[i], 0);
      chk($sformatf("%s/u%0d/ascii", name, i), ascii[i], 0);
      chk($sformatf("%s/u%0d/size", name, i), size[i], 0);
      chk($sformatf("%s/u%0d/overflow", name, i), ovf[i], 0);
      chk($sformatf("%s/u%0d/byte_bus", name, i), {bo[i], bv[i], bl[i]}, 0);
    end
  endtask

  initial begin
    int n;
    clear_mon();
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    tick();

    lens = '{5, 10, 3};
    clear_mon(); send_fields(0); wait_idle(0); check_msg("basic");

    lens = '{0};
    clear_mon(); send_fields(0); wait_idle(0); check_msg("zero");

    lens = '{20, 30};
    clear_mon(); send_fields(1); wait_idle(1); check_msg("base49");

    lens.delete();
    repeat (400) lens.push_back(255);
    clear_mon(); send_fields(0); wait_idle(1); check_msg("saturate");

    // Accepted start must clear the sticky overflow flag.
    lens = '{1};
    clear_mon();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NI; i++) chk($sformatf("ovf_clear/u%0d", i), ovf[i], 0);
    fld_valid = 1'b1; fld_len = 8'd1; fld_last = 1'b1;
    tick();
    fld_valid = 1'b0; fld_last = 1'b0;
    wait_idle(1); check_msg("post_sat");

    // Backpressure with ignored start pulses during EMIT.
    lens = '{5, 10, 3};
    clear_mon();
    byte_ready = 1'b0;
    send_fields(0);
    n = 0;
    while (!done[0] && n < 100) begin tick(); n++; end
    chk("bp/done_timeout", n < 100, 1);
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("bp/byte_r%0d", r), bo[0], 8'h32);
      chk($sformatf("bp/valid_r%0d", r), bv[0], 1);
      chk($sformatf("bp/fld_ready_r%0d", r), frdy[0], 0);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("bp/byte_after", bo[0], 8'h32);
    chk("bp/busy_after", busy[0], 1);
    wait_idle(0); check_msg("backpressure");

    // Reset in the middle of conversion.
    lens = '{7, 8};
    clear_mon();
    send_fields(0);
    repeat (5) tick();
    chk("mid_rst/busy_before", busy[0], 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_outputs_zero("mid_rst");
    repeat (30) tick();
    for (int i = 0; i < NI; i++) chk($sformatf("mid_rst/u%0d/no_done", i), done_cnt[i], 0);

    lens = '{40, 2, 9};
    clear_mon(); send_fields(1); wait_idle(1); check_msg("after_rst");

    for (int t = 0; t < 6; t++) begin
      lens.delete();
      n = $urandom_range(1, 8);
      for (int f = 0; f < n; f++) lens.push_back($urandom_range(0, 255));
      clear_mon(); send_fields(1); wait_idle(1); check_msg($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fix_bodylength_gen.md
Name: fix_bodylength_gen

Overview:
- Streaming BodyLength generator for the FIX message builder.
- Accumulates per-field byte counts from the field emitter, adds a configurable constant header length, and converts the total to ASCII decimal with a sequential double-dabble engine.
- Presents the result as a parallel, left-justified ASCII word plus a byte stream (valid/ready) for the serializer that inserts tag 9.
- Generalises the fixed-message-type length block: arbitrary field count, parametrised width and digit count, saturation, backpressure.

Parameters:
- LEN_WIDTH, 17: accumulator and binary width. Must satisfy 10^MAX_DIGITS-1+FLD_WIDTH_MAX+2 < 2^LEN_WIDTH.
- MAX_DIGITS, 5: ASCII digits supported. MAX_VAL = 10^MAX_DIGITS-1.
- FLD_WIDTH, 8: width of the per-field length input.
- BASE_LEN, 0: constant added at start, for precomputed fixed fields.
- ADD_DELIM, 1: when 1, each field adds 2 extra bytes ('=' and SOH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start_i  in  1  begin new message; honoured only in IDLE
- fld_valid_i  in  1  field length valid
- fld_ready_o  out  1  block accepts field lengths
- fld_len_i  in  FLD_WIDTH  byte count of tag+value
- fld_last_i  in  1  final field of message
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse; result valid
- ascii_o  out  8*MAX_DIGITS  ASCII result; byte k holds the k-th most significant digit; unused bytes 0x00
- size_o  out  $clog2(MAX_DIGITS+1)  number of significant digits
- overflow_o  out  1  sticky; total was saturated
- byte_o  out  8  serial ASCII digit
- byte_valid_o  out  1  serial digit valid
- byte_ready_i  in  1  downstream accepts digit
- byte_last_o  out  1  final digit

Behaviour:
- Reset (rst=0 at clk edge):
  - state IDLE; all outputs 0; accumulator, digit registers and overflow cleared.
  - Reset in any state aborts the operation; no done_o follows.
- IDLE:
  - fld_ready_o=0.
  - start_i=1 -> ACCUM; acc=BASE_LEN; overflow_o cleared.
- ACCUM:
  - fld_ready_o=1.
  - Each fld_valid_i&fld_ready_o: acc = min(acc + fld_len_i + (ADD_DELIM?2:0), MAX_VAL).
  - overflow_o set if the unclamped sum exceeds MAX_VAL.
  - A handshake with fld_last_i=1 -> CONVERT.
  - start_i is ignored outside IDLE.
- CONVERT:
  - fld_ready_o=0.
  - Iterative double-dabble over LEN_WIDTH cycles: add-3 to each BCD nibble >=5, then shift in the next binary bit, MSB first.
  - After the final shift -> EMIT.
  - Leading-zero suppression: size_o = index of the highest nonzero digit + 1; a value of 0 gives size_o=1, "0".
- EMIT:
  - Entry cycle: done_o=1 for one cycle; ascii_o and size_o valid and held until the next start_i is accepted.
  - Latency: done_o is high exactly LEN_WIDTH+1 cycles after the clock edge of the last field handshake.
  - byte_valid_o is first asserted in the done_o cycle. Digits are emitted most significant first, one per byte_valid_o&byte_ready_i.
  - byte_o, byte_valid_o and byte_last_o hold stable while byte_ready_i=0.
  - byte_last_o=1 on digit size_o-1; its handshake -> IDLE next cycle.
- ASCII digit = 0x30 + BCD nibble.
- overflow_o holds until the next accepted start_i or reset.

Decomposition:
- Shared package fix_pkg:
  - ASCII_ZERO=8'h30
  - DELIM_BYTES=2
  - state typedef {IDLE, ACCUM, CONVERT, EMIT}
  - function max_val(MAX_DIGITS)
- Sub-module bin2bcd_seq:
  - LEN_WIDTH-cycle double-dabble with start/done and BCD output.
  - Reusable by the checksum and msgSeqNum encoders.
- Top level contains the FSM, accumulator, leading-zero count and serializer.

Test Plan:
- Defaults; start; fields 5, 10, 3 (last) -> acc 24; done_o at last+18 cycles; ascii_o byte0=0x32, byte1=0x34, rest 0x00; size_o=2; serial stream 0x32, 0x34, last on 0x34; overflow_o=0.
- ADD_DELIM=0; single field len 0 (last) -> ascii "0" (byte0=0x30), size_o=1, one serial byte with byte_last_o=1.
- BASE_LEN=49; fields 20, 30 -> 103 -> bytes 0x31, 0x30, 0x33; size_o=3.
- 400 fields of 255 (ADD_DELIM=1, sum 102800) -> saturated 99999, overflow_o=1, five 0x39 bytes, size_o=5; the next start clears overflow_o.
- Backpressure: byte_ready_i low 3 cycles after done_o -> byte_o stays 0x32 with byte_valid_o high; start_i pulses during EMIT are ignored; fld_ready_o=0 throughout.
- rst=0 for one cycle mid-CONVERT -> next cycle all outputs 0 and state IDLE; no done_o; a new start then completes correctly.
